// File: rtl/neural_argmax_decoder.sv
// Streaming argmax decoder: running signed maximum over NUM_CLASSES serial
// scores, thresholded at frame end and presented under a valid/ready handshake.
`timescale 1ns/1ps

module neural_argmax_decoder #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W = 16,
  parameter logic signed [DATA_W-1:0] THRESH = 16'sh0400,
  localparam int unsigned IDX_W = $clog2(NUM_CLASSES + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] best_score,
  output logic              no_match,
  output logic [7:0]        seven_seg
);

  typedef enum logic {ACCUM = 1'b0, RESULT = 1'b1} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         cnt;
  logic [IDX_W-1:0]         best_idx;
  logic signed [DATA_W-1:0] best_val;

  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W-1:0] nxt_val;
  logic [IDX_W-1:0]         nxt_idx;
  logic                     nxt_nm;
  logic [7:0]               nxt_seg;
  logic                     accept;
  logic                     last;

  // Segment pattern {dp,g,f,e,d,c,b,a} for a class index; dp is never lit.
  function automatic logic [7:0] seg_encode(input logic [IDX_W-1:0] idx);
    logic [7:0] seg;
    case (int'(idx))
      0:       seg = 8'h3F;
      1:       seg = 8'h06;
      2:       seg = 8'h5B;
      3:       seg = 8'h4F;
      4:       seg = 8'h66;
      5:       seg = 8'h6D;
      6:       seg = 8'h7D;
      7:       seg = 8'h07;
      8:       seg = 8'h7F;
      9:       seg = 8'h6F;
      10:      seg = 8'h77;
      11:      seg = 8'h7C;
      12:      seg = 8'h39;
      13:      seg = 8'h5E;
      14:      seg = 8'h79;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  assign din    = in_data;
  // clear suppresses the accept even though in_ready stays high
  assign accept = in_valid && (state == ACCUM) && !clear;
  assign last   = accept && (cnt == IDX_W'(NUM_CLASSES - 1));

  // Candidate max including the current sample; first sample loads unconditionally,
  // strict greater-than keeps the lower index on ties.
  always_comb begin
    nxt_val = best_val;
    nxt_idx = best_idx;
    if ((cnt == '0) || (din > best_val)) begin
      nxt_val = din;
      nxt_idx = cnt;
    end
    nxt_nm  = !(nxt_val > THRESH);
    nxt_seg = nxt_nm ? 8'h40 : seg_encode(nxt_idx);
  end

  // Frame FSM, running max and registered result outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ACCUM;
      cnt          <= '0;
      best_val     <= '0;
      best_idx     <= '0;
      in_ready     <= 1'b1;
      result_valid <= 1'b0;
      class_idx    <= IDX_W'(NUM_CLASSES);
      best_score   <= '0;
      no_match     <= 1'b1;
      seven_seg    <= 8'h00;
    end else if (clear) begin
      state        <= ACCUM;
      cnt          <= '0;
      best_val     <= '0;
      best_idx     <= '0;
      in_ready     <= 1'b1;
      result_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            best_val <= nxt_val;
            best_idx <= nxt_idx;
            if (last) begin
              state        <= RESULT;
              cnt          <= '0;
              in_ready     <= 1'b0;
              result_valid <= 1'b1;
              class_idx    <= nxt_nm ? IDX_W'(NUM_CLASSES) : nxt_idx;
              best_score   <= nxt_val;
              no_match     <= nxt_nm;
              seven_seg    <= nxt_seg;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        RESULT: begin
          if (result_ready) begin
            state        <= ACCUM;
            in_ready     <= 1'b1;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= ACCUM;
          in_ready     <= 1'b1;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neural_argmax_decoder.sv
// Bench for neural_argmax_decoder: table of frames plus directed corner sequences,
// results checked through an expected-result queue.
`timescale 1ns/1ps

module tb_neural_argmax_decoder;

  localparam int NC = 10;

  logic        clk = 1'b0;
  logic        n_rst, clear, in_valid, in_ready, result_valid, result_ready, no_match;
  logic [15:0] in_data, best_score;
  logic [3:0]  class_idx;
  logic [7:0]  seven_seg;

  logic        v15, rdy15, rv15, rr15, nm15, clr15;
  logic [15:0] d15, bs15;
  logic [3:0]  ci15;
  logic [7:0]  ss15;

  always #5 clk = ~clk;

  neural_argmax_decoder dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .result_valid(result_valid), .result_ready(result_ready),
    .class_idx(class_idx), .best_score(best_score), .no_match(no_match), .seven_seg(seven_seg)
  );

  neural_argmax_decoder #(.NUM_CLASSES(15)) dut15 (
    .clk(clk), .n_rst(n_rst), .clear(clr15), .in_valid(v15), .in_data(d15),
    .in_ready(rdy15), .result_valid(rv15), .result_ready(rr15),
    .class_idx(ci15), .best_score(bs15), .no_match(nm15), .seven_seg(ss15)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] score;
    logic        nm;
    logic [7:0]  seg;
  } exp_t;

  typedef struct packed {
    logic              gaps;
    logic [NC-1:0][15:0] s;
    exp_t              e;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame of NC scores, all def except up to two overrides (index -1 = unused).
  function automatic logic [NC-1:0][15:0] mk(input logic [15:0] def, input int i1,
                                             input logic [15:0] v1, input int i2,
                                             input logic [15:0] v2);
    logic [NC-1:0][15:0] r;
    for (int k = 0; k < NC; k++) r[k] = def;
    if (i1 >= 0) r[i1] = v1;
    if (i2 >= 0) r[i2] = v2;
    return r;
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [NC-1:0][15:0] s, input logic gaps);
    for (int k = 0; k < NC; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = s[k];
      wait_ready();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_partial(input int n, input logic [15:0] val);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = val;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send15(input int hi_idx, input logic [15:0] hi, input logic [15:0] def);
    for (int k = 0; k < 15; k++) begin
      int t = 0;
      v15 = 1'b1;
      d15 = (k == hi_idx) ? hi : def;
      while (!rdy15 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!rdy15) check("in_ready15_timeout", 32'(rdy15), 32'd1);
      @(posedge clk); #1;
    end
    v15 = 1'b0;
  endtask

  // Scoreboard: compare the oldest expected result whenever a handshake completes.
  always @(negedge clk) begin
    if (n_rst && result_valid && result_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("class_idx",  32'(class_idx),  32'(mon_e.idx));
        check("best_score", 32'(best_score), 32'(mon_e.score));
        check("no_match",   32'(no_match),   32'(mon_e.nm));
        check("seven_seg",  32'(seven_seg),  32'(mon_e.seg));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; result_ready = 1'b1;
    v15 = 1'b0; d15 = '0; rr15 = 1'b1; clr15 = 1'b0;

    vecs[0] = '{gaps: 1'b0, s: mk(16'h0000, 1, 16'h0100, 7, 16'h0800),
                e: '{idx: 4'd7,  score: 16'h0800, nm: 1'b0, seg: 8'h07}};
    vecs[1] = '{gaps: 1'b0, s: mk(16'h0400, -1, 16'h0, -1, 16'h0),
                e: '{idx: 4'd10, score: 16'h0400, nm: 1'b1, seg: 8'h40}};
    vecs[2] = '{gaps: 1'b0, s: mk(16'hF000, 3, 16'hFF00, -1, 16'h0),
                e: '{idx: 4'd10, score: 16'hFF00, nm: 1'b1, seg: 8'h40}};
    vecs[3] = '{gaps: 1'b0, s: mk(16'h0000, 2, 16'h0900, 5, 16'h0900),
                e: '{idx: 4'd2,  score: 16'h0900, nm: 1'b0, seg: 8'h5B}};
    vecs[4] = '{gaps: 1'b0, s: mk(16'h0000, 9, 16'h0500, -1, 16'h0),
                e: '{idx: 4'd9,  score: 16'h0500, nm: 1'b0, seg: 8'h6F}};
    vecs[5] = '{gaps: 1'b0, s: mk(16'h8000, 0, 16'h7FFF, -1, 16'h0),
                e: '{idx: 4'd0,  score: 16'h7FFF, nm: 1'b0, seg: 8'h3F}};
    vecs[6] = '{gaps: 1'b0, s: mk(16'h0000, 4, 16'h0401, -1, 16'h0),
                e: '{idx: 4'd4,  score: 16'h0401, nm: 1'b0, seg: 8'h66}};
    vecs[7] = '{gaps: 1'b1, s: mk(16'h0000, 1, 16'h0100, 7, 16'h0800),
                e: '{idx: 4'd7,  score: 16'h0800, nm: 1'b0, seg: 8'h07}};

    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk); #1;

    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_in_ready",     32'(in_ready),     32'd1);
    check("rst_class_idx",    32'(class_idx),    32'd10);
    check("rst_best_score",   32'(best_score),   32'd0);
    check("rst_no_match",     32'(no_match),     32'd1);
    check("rst_seven_seg",    32'(seven_seg),    32'd0);
    check("rst_class_idx15",  32'(ci15),         32'd15);

    // Table-driven frames with result_ready held high.
    for (int i = 0; i < 8; i++) begin
      sb.push_back(vecs[i].e);
      send(vecs[i].s, vecs[i].gaps);
      check("rv_after_last",   32'(result_valid), 32'd1);
      check("busy_after_last", 32'(in_ready),     32'd0);
      @(posedge clk); #1;
      check("rv_dropped",      32'(result_valid), 32'd0);
      check("ready_back",      32'(in_ready),     32'd1);
    end

    // Backpressure: result held, in_valid ignored while in RESULT.
    result_ready = 1'b0;
    sb.push_back(vecs[3].e);
    send(vecs[3].s, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h7FFF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_rv",        32'(result_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),     32'd0);
      check("bp_class_idx", 32'(class_idx),    32'd2);
      check("bp_seven_seg", 32'(seven_seg),    32'h5B);
    end
    in_valid     = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_rv", 32'(result_valid), 32'd0);
    sb.push_back(vecs[4].e);
    send(vecs[4].s, 1'b0);
    @(posedge clk); #1;

    // clear after four accepts discards the partial frame.
    send_partial(4, 16'h7000);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h7FFF;
    #1 check("clear_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_keeps_idx", 32'(class_idx),    32'd9);
    check("clear_keeps_seg", 32'(seven_seg),    32'h6F);
    check("clear_rv",        32'(result_valid), 32'd0);
    sb.push_back(vecs[4].e);
    send(vecs[4].s, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset after six accepts.
    send_partial(6, 16'h7000);
    #2 n_rst = 1'b0;
    #1;
    check("arst_class_idx",  32'(class_idx),    32'd10);
    check("arst_best_score", 32'(best_score),   32'd0);
    check("arst_no_match",   32'(no_match),     32'd1);
    check("arst_seven_seg",  32'(seven_seg),    32'd0);
    check("arst_rv",         32'(result_valid), 32'd0);
    check("arst_in_ready",   32'(in_ready),     32'd1);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    sb.push_back(vecs[0].e);
    send(vecs[0].s, 1'b0);
    @(posedge clk); #1;

    // Fifteen-class instance: top index and the no-match index.
    send15(14, 16'h0600, 16'h0100);
    check("c15_rv",         32'(rv15), 32'd1);
    check("c15_class_idx",  32'(ci15), 32'd14);
    check("c15_seven_seg",  32'(ss15), 32'h79);
    check("c15_best_score", 32'(bs15), 32'h0600);
    check("c15_no_match",   32'(nm15), 32'd0);
    @(posedge clk); #1;
    send15(-1, 16'h0000, 16'h0300);
    check("c15nm_class_idx",  32'(ci15), 32'd15);
    check("c15nm_seven_seg",  32'(ss15), 32'h40);
    check("c15nm_best_score", 32'(bs15), 32'h0300);
    check("c15nm_no_match",   32'(nm15), 32'd1);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
